// File: rtl/encoder_4x2_rr.sv
// encoder_4x2_rr: registered 4-input round-robin encoder with valid/ready output.
// Active-low requests are sampled into req_p0 on every edge. A two-state output
// stage (EMPTY/FULL) grants the first request found circularly from ptr and
// holds the grant stable until the downstream handshake completes.
module encoder_4x2_rr (
  input  logic       clock,
  input  logic       reset,
  input  logic [0:3] D,
  input  logic       enable,
  input  logic       ready,
  output logic [1:0] code,
  output logic       valid,
  output logic [2:0] count
);

  localparam logic [0:0] EMPTY = 1'b0;
  localparam logic [0:0] FULL  = 1'b1;

  logic [3:0] req_in;
  logic [3:0] req_p0;
  logic [0:0] state_p1;
  logic [1:0] ptr_p1;
  logic [1:0] ptr_hs;

  // First set request index, searching start, start+1, ... modulo 4.
  function automatic logic [1:0] rr_pick(input logic [3:0] req, input logic [1:0] start);
    logic [1:0] idx;
    logic [1:0] sel;
    logic       found;
    sel   = start;
    found = 1'b0;
    for (int k = 0; k < 4; k++) begin
      idx = start + 2'(k);
      if (!found && req[idx]) begin
        sel   = idx;
        found = 1'b1;
      end
    end
    return sel;
  endfunction

  // Number of active requests; 3 bits so that all four requests read as 4.
  function automatic logic [2:0] popcount4(input logic [3:0] req);
    logic [2:0] sum;
    sum = 3'd0;
    for (int k = 0; k < 4; k++) begin
      sum = sum + 3'(req[k]);
    end
    return sum;
  endfunction

  // Convert active-low request lines and active-low enable into active-high requests.
  always_comb begin
    req_in = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      req_in[i] = ~D[i] & ~enable;
    end
  end

  // Pointer that a completing handshake hands to the next search (3 wraps to 0).
  assign ptr_hs = code + 2'd1;

  // Stage p0: sample requests; count trails the request register by one edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      req_p0 <= 4'b0000;
      count  <= 3'd0;
    end else begin
      req_p0 <= req_in;
      count  <= popcount4(req_p0);
    end
  end

  // Stage p1: output state machine; grant held bit-stable while stalled.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_p1 <= EMPTY;
      code     <= 2'd0;
      ptr_p1   <= 2'd0;
    end else begin
      case (state_p1)
        EMPTY: begin
          if (|req_p0) begin
            state_p1 <= FULL;
            code     <= rr_pick(req_p0, ptr_p1);
          end
        end
        default: begin
          if (ready) begin
            ptr_p1 <= ptr_hs;
            if (|req_p0) begin
              code <= rr_pick(req_p0, ptr_hs);
            end else begin
              state_p1 <= EMPTY;
            end
          end
        end
      endcase
    end
  end

  assign valid = (state_p1 == FULL);

endmodule
